// File: rtl/tlb_array.sv
// Fully associative joint TLB: TLBWI write port, TLBR read port, two independent lookup ports.
// Optional sticky multi-hit detection is built only when TLB_MHIT_CHK_EN is defined.
module tlb_array #(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  // lookup port 0 (instruction fetch)
  input  logic [18:0]   s0_vpn2,
  input  logic          s0_odd_page,
  input  logic [7:0]    s0_asid,
  output logic          s0_found,
  output logic [IW-1:0] s0_index,
  output logic [19:0]   s0_pfn,
  output logic [2:0]    s0_c,
  output logic          s0_d,
  output logic          s0_v,
  // lookup port 1 (data access / TLBP)
  input  logic [18:0]   s1_vpn2,
  input  logic          s1_odd_page,
  input  logic [7:0]    s1_asid,
  output logic          s1_found,
  output logic [IW-1:0] s1_index,
  output logic [19:0]   s1_pfn,
  output logic [2:0]    s1_c,
  output logic          s1_d,
  output logic          s1_v,
  // TLBWI write port
  input  logic          we,
  input  logic [IW-1:0] w_index,
  input  logic [18:0]   w_vpn2,
  input  logic [7:0]    w_asid,
  input  logic          w_g,
  input  logic [19:0]   w_pfn0,
  input  logic [2:0]    w_c0,
  input  logic          w_d0,
  input  logic          w_v0,
  input  logic [19:0]   w_pfn1,
  input  logic [2:0]    w_c1,
  input  logic          w_d1,
  input  logic          w_v1,
  // TLBR read port
  input  logic [IW-1:0] r_index,
  output logic [18:0]   r_vpn2,
  output logic [7:0]    r_asid,
  output logic          r_g,
  output logic [19:0]   r_pfn0,
  output logic [2:0]    r_c0,
  output logic          r_d0,
  output logic          r_v0,
  output logic [19:0]   r_pfn1,
  output logic [2:0]    r_c1,
  output logic          r_d1,
  output logic          r_v1,
  // multi-hit flag
  input  logic          mhit_clr,
  output logic          mhit
);

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    page_t       p0;
    page_t       p1;
  } entry_t;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] index;
    page_t         page;
  } lookup_t;

  entry_t              entry_q [TLBNUM];
  logic [TLBNUM-1:0]   e_q;

  // NOTE: the whole array is reset explicitly because reset must leave every entry
  // readable as zero; this keeps it in flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) entry_q[i] <= '0;
      e_q <= '0;
    end else if (we) begin
      entry_q[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                            p0: '{pfn: w_pfn0, c: w_c0, d: w_d0, v: w_v0},
                            p1: '{pfn: w_pfn1, c: w_c1, d: w_d1, v: w_v1}};
      e_q[w_index]     <= 1'b1;
    end
  end

  // Port inputs gathered into arrays so both lookup ports share one generate body.
  logic [18:0] s_vpn2 [2];
  logic [7:0]  s_asid [2];
  logic        s_odd  [2];
  lookup_t     lk     [2];
  logic [1:0]  multi;

  assign s_vpn2[0] = s0_vpn2;
  assign s_vpn2[1] = s1_vpn2;
  assign s_asid[0] = s0_asid;
  assign s_asid[1] = s1_asid;
  assign s_odd[0]  = s0_odd_page;
  assign s_odd[1]  = s1_odd_page;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [TLBNUM-1:0] match;
    logic [IW-1:0]     hit_idx;
    lookup_t           res;

    // NOTE: every always_comb assigns its outputs a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++) begin
        match[i] = e_q[i] && (entry_q[i].vpn2 == s_vpn2[p]) &&
                   (entry_q[i].g || (entry_q[i].asid == s_asid[p]));
      end
    end

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
      hit_idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (match[i]) hit_idx = IW'(i);
      end
    end

    always_comb begin
      res = '0;
      if (|match) begin
        res.found = 1'b1;
        res.index = hit_idx;
        res.page  = s_odd[p] ? entry_q[hit_idx].p1 : entry_q[hit_idx].p0;
      end
    end

    assign lk[p] = res;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi[p] = |(match & (match - 1'b1));
  end

  assign s0_found = lk[0].found;
  assign s0_index = lk[0].index;
  assign s0_pfn   = lk[0].page.pfn;
  assign s0_c     = lk[0].page.c;
  assign s0_d     = lk[0].page.d;
  assign s0_v     = lk[0].page.v;

  assign s1_found = lk[1].found;
  assign s1_index = lk[1].index;
  assign s1_pfn   = lk[1].page.pfn;
  assign s1_c     = lk[1].page.c;
  assign s1_d     = lk[1].page.d;
  assign s1_v     = lk[1].page.v;

  assign r_vpn2 = entry_q[r_index].vpn2;
  assign r_asid = entry_q[r_index].asid;
  assign r_g    = entry_q[r_index].g;
  assign r_pfn0 = entry_q[r_index].p0.pfn;
  assign r_c0   = entry_q[r_index].p0.c;
  assign r_d0   = entry_q[r_index].p0.d;
  assign r_v0   = entry_q[r_index].p0.v;
  assign r_pfn1 = entry_q[r_index].p1.pfn;
  assign r_c1   = entry_q[r_index].p1.c;
  assign r_d1   = entry_q[r_index].p1.d;
  assign r_v1   = entry_q[r_index].p1.v;

`ifdef TLB_MHIT_CHK_EN
  logic mhit_q;

  // A fresh multi-hit outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset)          mhit_q <= 1'b0;
    else if (|multi)    mhit_q <= 1'b1;
    else if (mhit_clr)  mhit_q <= 1'b0;
  end

  assign mhit = mhit_q;
`else
  logic unused_mhit;
  assign unused_mhit = mhit_clr ^ (|multi);
  assign mhit        = 1'b0;
`endif

endmodule

// File: tb/tb_tlb_array.sv
// Directed self-checking bench for tlb_array: expected values queued on a scoreboard when
// stimulus is driven, popped and asserted at the following negedge.
module tb_tlb_array;
  localparam int TLBNUM = 16;
  localparam int IW     = 4;
`ifdef TLB_MHIT_CHK_EN
  localparam logic MHIT_EN = 1'b1;
`else
  localparam logic MHIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [18:0]   s0_vpn2, s1_vpn2;
  logic          s0_odd_page, s1_odd_page;
  logic [7:0]    s0_asid, s1_asid;
  logic          s0_found, s1_found;
  logic [IW-1:0] s0_index, s1_index;
  logic [19:0]   s0_pfn, s1_pfn;
  logic [2:0]    s0_c, s1_c;
  logic          s0_d, s1_d, s0_v, s1_v;
  logic          we;
  logic [IW-1:0] w_index, r_index;
  logic [18:0]   w_vpn2, r_vpn2;
  logic [7:0]    w_asid, r_asid;
  logic          w_g, r_g;
  logic [19:0]   w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]    w_c0, w_c1, r_c0, r_c1;
  logic          w_d0, w_v0, w_d1, w_v1, r_d0, r_v0, r_d1, r_v1;
  logic          mhit_clr, mhit;

  tlb_array #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .mhit_clr(mhit_clr), .mhit(mhit)
  );

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0, v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1, v1;
  } ent_t;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [127:0] val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic pop_check(input logic [127:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check("sb_empty", 128'd1, 128'd0);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, obs, it.val);
    end
  endtask

  task automatic expect_lk(input string tag, input logic f, input logic [3:0] idx,
                           input logic [19:0] pfn, input logic [2:0] c, input logic d, input logic v);
    push(tag, 128'({f, idx, pfn, c, d, v}));
  endtask

  task automatic check_lk(input int port);
    if (port == 0) pop_check(128'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}));
    else           pop_check(128'({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}));
  endtask

  task automatic check_rd();
    pop_check(128'({r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}));
  endtask

  task automatic set_s(input int port, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    if (port == 0) begin s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid; end
    else           begin s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid; end
  endtask

  task automatic wr_start(input logic [3:0] idx, input ent_t e);
    we = 1'b1; w_index = idx;
    {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1} = e;
  endtask

  task automatic write(input logic [3:0] idx, input ent_t e);
    wr_start(idx, e);
    tick();
    we = 1'b0;
  endtask

  ent_t e3, e3g, e3n, e7, e2, e15, e5;

  initial begin
    reset = 1'b1; we = 1'b0; mhit_clr = 1'b0; r_index = '0; w_index = '0;
    {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1} = '0;
    set_s(0, 19'h0, 1'b0, 8'h0);
    set_s(1, 19'h0, 1'b0, 8'h0);

    e3  = '{vpn2: 19'h12345, asid: 8'h05, g: 1'b0, pfn0: 20'h11111, c0: 3'd0, d0: 1'b0, v0: 1'b1,
            pfn1: 20'h22222, c1: 3'd3, d1: 1'b1, v1: 1'b1};
    e3g = e3;  e3g.g = 1'b1;
    e3n = e3g; e3n.vpn2 = 19'h0abcd;
    e7  = '{vpn2: 19'h33333, asid: 8'h09, g: 1'b0, pfn0: 20'h77777, c0: 3'd2, d0: 1'b0, v0: 1'b1,
            pfn1: 20'h77778, c1: 3'd2, d1: 1'b0, v1: 1'b0};
    e2  = '{vpn2: 19'h33333, asid: 8'h09, g: 1'b0, pfn0: 20'h22220, c0: 3'd5, d0: 1'b1, v0: 1'b0,
            pfn1: 20'h22221, c1: 3'd1, d1: 1'b0, v1: 1'b1};
    e15 = '{vpn2: 19'h7ffff, asid: 8'hff, g: 1'b0, pfn0: 20'hfffff, c0: 3'd7, d0: 1'b1, v0: 1'b1,
            pfn1: 20'h0000f, c1: 3'd0, d1: 1'b0, v1: 1'b0};
    e5  = '{vpn2: 19'h55555, asid: 8'h01, g: 1'b1, pfn0: 20'h55555, c0: 3'd3, d0: 1'b1, v0: 1'b1,
            pfn1: 20'h55556, c1: 3'd3, d1: 1'b1, v1: 1'b1};

    tick(); tick();
    reset = 1'b0;

    // Reset state
    set_s(0, 19'h12345, 1'b0, 8'h05);
    r_index = 4'd0;
    expect_lk("rst_s0", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    push("rst_rd0", 128'(ent_t'('0)));
    push("rst_mhit", 128'(1'b0));
    sample();
    check_lk(0); check_rd(); pop_check(128'(mhit));

    // Basic write and both page halves
    tick();
    write(4'd3, e3);
    set_s(1, 19'h12345, 1'b1, 8'h05);
    set_s(0, 19'h12345, 1'b1, 8'h05);
    r_index = 4'd3;
    expect_lk("odd_s1", 1'b1, 4'd3, 20'h22222, 3'd3, 1'b1, 1'b1);
    expect_lk("odd_s0_same", 1'b1, 4'd3, 20'h22222, 3'd3, 1'b1, 1'b1);
    push("rd3", 128'(e3));
    sample();
    check_lk(1); check_lk(0); check_rd();
    tick();
    set_s(1, 19'h12345, 1'b0, 8'h05);
    expect_lk("even_s1", 1'b1, 4'd3, 20'h11111, 3'd0, 1'b0, 1'b1);
    sample(); check_lk(1);

    // ASID mismatch, then global rewrite observed only after the write edge
    tick();
    set_s(1, 19'h12345, 1'b0, 8'h06);
    expect_lk("asid_miss", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    sample(); check_lk(1);
    tick();
    wr_start(4'd3, e3g);
    expect_lk("g_wcycle_miss", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    push("g_wcycle_rd_old", 128'(e3));
    sample(); check_lk(1); check_rd();
    tick(); we = 1'b0;
    expect_lk("g_hit", 1'b1, 4'd3, 20'h11111, 3'd0, 1'b0, 1'b1);
    push("g_rd_new", 128'(e3g));
    sample(); check_lk(1); check_rd();

    // New VPN2 during the write cycle: old contents, then hit
    tick();
    wr_start(4'd3, e3n);
    set_s(0, 19'h0abcd, 1'b1, 8'h06);
    expect_lk("wcycle_miss", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    push("wcycle_rd_old", 128'(e3g));
    sample(); check_lk(0); check_rd();
    tick(); we = 1'b0;
    expect_lk("post_w_hit", 1'b1, 4'd3, 20'h22222, 3'd3, 1'b1, 1'b1);
    push("post_w_rd", 128'(e3n));
    sample(); check_lk(0); check_rd();

    // Highest index boundary
    tick();
    write(4'd15, e15);
    set_s(1, 19'h7ffff, 1'b0, 8'hff);
    expect_lk("idx15", 1'b1, 4'd15, 20'hfffff, 3'd7, 1'b1, 1'b1);
    sample(); check_lk(1);

    // Duplicate entries: lowest index wins, sticky multi-hit flag
    tick();
    set_s(0, 19'h44444, 1'b0, 8'h09);
    set_s(1, 19'h0abcd, 1'b0, 8'h06);
    write(4'd7, e7);
    write(4'd2, e2);
    set_s(0, 19'h33333, 1'b0, 8'h09);
    expect_lk("dup_lowest", 1'b1, 4'd2, 20'h22220, 3'd5, 1'b1, 1'b0);
    push("mhit_before", 128'(1'b0));
    sample(); check_lk(0); pop_check(128'(mhit));
    tick();
    set_s(0, 19'h44444, 1'b0, 8'h09);
    push("mhit_set", 128'(MHIT_EN));
    sample(); pop_check(128'(mhit));
    tick();
    push("mhit_sticky", 128'(MHIT_EN));
    sample(); pop_check(128'(mhit));
    set_s(0, 19'h33333, 1'b0, 8'h09);
    mhit_clr = 1'b1;
    tick();
    push("mhit_set_over_clr", 128'(MHIT_EN));
    sample(); pop_check(128'(mhit));
    set_s(0, 19'h44444, 1'b0, 8'h09);
    tick();
    mhit_clr = 1'b0;
    push("mhit_cleared", 128'(1'b0));
    sample(); pop_check(128'(mhit));

    // Reset beats a same-cycle write
    tick();
    wr_start(4'd5, e5);
    reset = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0;
    set_s(0, 19'h55555, 1'b0, 8'h01);
    set_s(1, 19'h0abcd, 1'b0, 8'h06);
    r_index = 4'd5;
    expect_lk("rst_we_miss", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    expect_lk("rst_clears_3", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
    push("rst_we_rd5", 128'(ent_t'('0)));
    push("rst_mhit2", 128'(1'b0));
    sample(); check_lk(0); check_lk(1); check_rd(); pop_check(128'(mhit));

    if (sb_q.size() != 0) check("sb_leftover", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
